// File: rtl/gray_step_monitor.sv
// Gray-stream step checker: decodes each sampled Gray word and classifies it
// against the previous word as a +1/-1 step, a repeat, or an illegal jump.
module gray_step_monitor #(
  parameter int W     = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_valid,
  input  logic [W-1:0]     g_in,
  input  logic             clr,
  output logic [W-1:0]     b_out,
  output logic             b_valid,
  output logic             step_ok,
  output logic             dir_up,
  output logic             hold,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  typedef enum logic {EMPTY, TRACK} state_t;

  localparam logic [W-1:0]     ONE_W   = W'(1);
  localparam logic [ERR_W-1:0] ONE_ERR = ERR_W'(1);

  state_t           state, state_n;
  logic [W-1:0]     bin, diff, ref_q, ref_n, b_out_n;
  logic             b_valid_n, step_ok_n, dir_up_n, hold_n, step_err_n;
  logic [ERR_W-1:0] err_cnt_n;

  // Each binary bit is the XOR of its Gray bit and all higher Gray bits,
  // accumulated here as a prefix XOR of right-shifted copies.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bin = bin ^ (g_in >> i);
    end
  end

  assign diff = bin - ref_q;

  always_comb begin
    state_n    = state;
    ref_n      = ref_q;
    b_out_n    = b_out;
    b_valid_n  = 1'b0;
    step_ok_n  = 1'b0;
    dir_up_n   = dir_up;
    hold_n     = 1'b0;
    step_err_n = 1'b0;
    err_cnt_n  = err_cnt;

    if (clr) begin
      state_n   = EMPTY;
      ref_n     = '0;
      err_cnt_n = '0;
    end else if (g_valid) begin
      state_n   = TRACK;
      ref_n     = bin;
      b_out_n   = bin;
      b_valid_n = 1'b1;
      if (state == TRACK) begin
        if (diff == ONE_W) begin
          step_ok_n = 1'b1;
          dir_up_n  = 1'b1;
        end else if (diff == '1) begin
          step_ok_n = 1'b1;
          dir_up_n  = 1'b0;
        end else if (diff == '0) begin
          hold_n = 1'b1;
        end else begin
          step_err_n = 1'b1;
          if (err_cnt != '1) begin
            err_cnt_n = err_cnt + ONE_ERR;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ref_q    <= '0;
      b_out    <= '0;
      b_valid  <= 1'b0;
      step_ok  <= 1'b0;
      dir_up   <= 1'b0;
      hold     <= 1'b0;
      step_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      ref_q    <= ref_n;
      b_out    <= b_out_n;
      b_valid  <= b_valid_n;
      step_ok  <= step_ok_n;
      dir_up   <= dir_up_n;
      hold     <= hold_n;
      step_err <= step_err_n;
      err_cnt  <= err_cnt_n;
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the binary-to-Gray converter.
- Samples a stream of W-bit Gray words, decodes each word back to binary and checks that every new word is a legal single step from the previous one: +1, -1 or a repeat.
- Reports direction of travel and counts illegal jumps.
- Used to close the loop on Gray counter and encoder paths, and to monitor them in-system.

Parameters:
W, 4, Gray/binary word width; legal range W >= 2.
ERR_W, 8, width of the saturating error counter.

Ports:
clk       input   1      rising-edge clock
rst       input   1      synchronous reset, active-high
g_valid   input   1      g_in is sampled on this clk edge
g_in      input   W      Gray-coded input word
clr       input   1      synchronous soft clear: drop the reference word, zero err_cnt
b_out     output  W      registered binary decode of the last accepted word
b_valid   output  1      1-cycle pulse: b_out updated
step_ok   output  1      1-cycle pulse: legal +/-1 step
dir_up    output  1      1 = increment, 0 = decrement; meaningful only with step_ok
hold      output  1      1-cycle pulse: same word repeated
step_err  output  1      1-cycle pulse: illegal jump
err_cnt   output  ERR_W  saturating count of illegal jumps
locked    output  1      1 while a reference word is held (state TRACK)

Behaviour:
- **Reset** (rst=1 at clk edge): every output and internal register goes to 0, and the state goes to EMPTY. Reset overrides clr and g_valid. Reset mid-stream discards the reference word.
- **Decode:** bin[W-1] = g[W-1]; bin[i] = bin[i+1] XOR g[i] for i = W-2 down to 0. The decoder is purely combinational on g_in and registered into b_out.
- **Latency:** all outputs are registered and appear 1 cycle after the edge where g_valid=1 is sampled.
- **Pulse outputs** (b_valid, step_ok, hold, step_err): 0 in any cycle that does not follow an accepted sample. At most one of step_ok / hold / step_err is 1 in any cycle.
- **dir_up:** holds its last value when step_ok=0.
- **State EMPTY** (locked=0):
  - g_valid=1 → store bin as the reference, b_out=bin, b_valid=1, step_ok/hold/step_err=0, go to TRACK.
  - g_valid=0 → stay in EMPTY.
- **State TRACK** (locked=1), on g_valid=1, with d = (bin - ref) mod 2^W:
  - d=1: step_ok=1, dir_up=1. This includes wrap 2^W-1 → 0.
  - d=2^W-1: step_ok=1, dir_up=0. This includes wrap 0 → 2^W-1.
  - d=0: hold=1; no error.
  - any other d: step_err=1; err_cnt increments unless already at 2^ERR_W-1, where it stays.
  - In every case, ref = bin, b_out = bin and b_valid=1. The monitor resynchronises to the new word even after an error.
- **W=2 special case:** d=1 and d=3 are distinct values, so the rules above apply unchanged. d=2 is an error.
- **Saturation:** err_cnt saturates and does not wrap. step_err still pulses on every error once saturated.
- **clr=1** (with rst=0):
  - Next state is EMPTY, locked=0, err_cnt=0, ref cleared; b_out holds its value.
  - A g_valid in the same cycle is discarded: no b_valid, no step pulse.
  - clr has priority over g_valid.
- **g_valid=0 in TRACK:** the reference, b_out and err_cnt hold their values; there is no timeout.

Test Plan:
1. **Reset:** assert rst 2 cycles while driving g_valid=1, g_in=4'b0101. Required: all outputs 0, locked=0 throughout and after release, with no b_valid pulse.
2. **Up count with wrap:** after reset, feed Gray words for 0..15 then 0 on consecutive cycles (0000, 0001, 0011, 0010, ..., 1000, 0000). Required:
   - b_out tracks 0, 1, ..., 15, 0, each 1 cycle after input.
   - First sample: b_valid=1, step_ok=0, locked goes 1.
   - Next 16 samples: step_ok=1 and dir_up=1, including 1000→0000.
   - err_cnt=0 at the end.
3. **Down step and wrap:** feed 0000 then 1000 then 1001. Required: b_out 0, 15, 14; both steps give step_ok=1 with dir_up=0.
4. **Illegal jump, repeat and resync:** feed 0001 (1), 0110 (4), 0110 (4), 0111 (5). Required:
   - 0110 (4): step_err=1, err_cnt=1, b_out=4.
   - Repeated 0110: hold=1 with step_err=0.
   - 0111 (5): step_ok=1, dir_up=1.
5. **Saturation and clr (ERR_W=2):**
   - Feed 0000, then four jumps 0110, 0000, 0110, 0000. Required: step_err pulses 4 times; err_cnt goes 1, 2, 3, 3.
   - Then assert clr together with g_valid=1, g_in=0001. Required: next cycle locked=0, err_cnt=0, b_valid=0.
   - The following valid word re-locks with no step pulse.
6. **Reset mid-stream:** while in TRACK with err_cnt=2, pulse rst for 1 cycle, then feed 0011. Required: outputs cleared, and 0011 is treated as a first sample (b_out=2, b_valid=1, no step_err).
